thread_register_file: RTL and testbench

//  Per-thread register bank for one compute core; the operand source and result sink for the ALU.

---
 rtl/thread_register_file.sv | 94 +++++++++
 tb/tb_thread_register_file.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/thread_register_file.sv
//------------------------------------------------------------------------------
// Module      : thread_register_file
// Description : Per-lane register bank feeding ALU/LSU operands and taking
//               back ALU, LSU or immediate results; R13..R15 hold SIMT ids.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module thread_register_file #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS         = 8,
  parameter int NUM_REGS          = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic [2:0]                                    core_state,
  input  logic [THREADS_PER_BLOCK-1:0]                  thread_mask,
  input  logic [7:0]                                    block_id,
  input  logic [3:0]                                    decoded_rd_address,
  input  logic [3:0]                                    decoded_rs_address,
  input  logic [3:0]                                    decoded_rt_address,
  input  logic                                          decoded_reg_write_enable,
  input  logic [1:0]                                    decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0]                          decoded_immediate,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]   alu_out,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]   lsu_out,
  output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]   rs,
  output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]   rt
);

  localparam logic [2:0] c_STATE_REQUEST = 3'b011;
  localparam logic [2:0] c_STATE_UPDATE  = 3'b110;
  localparam logic [1:0] c_MUX_ALU       = 2'b00;
  localparam logic [1:0] c_MUX_LSU       = 2'b01;
  localparam logic [1:0] c_MUX_IMM       = 2'b10;
  localparam logic [1:0] c_MUX_NONE      = 2'b11;
  localparam logic [3:0] c_FIRST_RO_REG  = 4'd13;

  logic w_read_cycle;
  logic w_write_cycle;

  assign w_read_cycle  = enable && (core_state == c_STATE_REQUEST);
  // R13..R15 are identity registers; writes aimed at them vanish silently
  assign w_write_cycle = enable && (core_state == c_STATE_UPDATE) &&
                         decoded_reg_write_enable &&
                         (decoded_reg_input_mux != c_MUX_NONE) &&
                         (decoded_rd_address < c_FIRST_RO_REG);

  for (genvar gi = 0; gi < THREADS_PER_BLOCK; gi++) begin : g_lane
    logic [DATA_BITS-1:0] r_regs [NUM_REGS];
    logic [DATA_BITS-1:0] r_rs;
    logic [DATA_BITS-1:0] r_rt;
    logic [DATA_BITS-1:0] w_wdata;

    always_comb begin
      w_wdata = alu_out[gi];
      case (decoded_reg_input_mux)
        c_MUX_ALU: w_wdata = alu_out[gi];
        c_MUX_LSU: w_wdata = lsu_out[gi];
        c_MUX_IMM: w_wdata = decoded_immediate;
        default:   w_wdata = alu_out[gi];
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          r_regs[r] <= '0;
        end
        r_regs[14] <= DATA_BITS'(THREADS_PER_BLOCK);
        r_regs[15] <= DATA_BITS'(gi);
        r_rs       <= '0;
        r_rt       <= '0;
      end else if (enable) begin
        // Refresh ignores the lane mask; same-cycle reads see the old value
        r_regs[13] <= DATA_BITS'(block_id);
        if (w_write_cycle && thread_mask[gi]) begin
          r_regs[decoded_rd_address] <= w_wdata;
        end
        if (w_read_cycle && thread_mask[gi]) begin
          r_rs <= r_regs[decoded_rs_address];
          r_rt <= r_regs[decoded_rt_address];
        end
      end
    end

    assign rs[gi] = r_rs;
    assign rt[gi] = r_rt;
  end

endmodule

`default_nettype wire

// File: tb/tb_thread_register_file.sv
//------------------------------------------------------------------------------
// Module      : tb_thread_register_file
// Description : Directed and randomized check of thread_register_file against
//               an array-based reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_thread_register_file;

  localparam int T = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [2:0]        core_state;
  logic [T-1:0]      thread_mask;
  logic [7:0]        block_id;
  logic [3:0]        rd_addr, rs_addr, rt_addr;
  logic              reg_we;
  logic [1:0]        reg_mux;
  logic [7:0]        imm;
  logic [T-1:0][7:0] alu_out, lsu_out;
  logic [T-1:0][7:0] rs, rt;

  logic [7:0] m_reg [T][16];
  logic [7:0] m_rs  [T];
  logic [7:0] m_rt  [T];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  thread_register_file dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .thread_mask              (thread_mask),
    .block_id                 (block_id),
    .decoded_rd_address       (rd_addr),
    .decoded_rs_address       (rs_addr),
    .decoded_rt_address       (rt_addr),
    .decoded_reg_write_enable (reg_we),
    .decoded_reg_input_mux    (reg_mux),
    .decoded_immediate        (imm),
    .alu_out                  (alu_out),
    .lsu_out                  (lsu_out),
    .rs                       (rs),
    .rt                       (rt)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, apply the behavioural rules to the model, compare outputs
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int l = 0; l < T; l++) begin
        for (int r = 0; r < 16; r++) m_reg[l][r] = 8'd0;
        m_reg[l][14] = 8'(T);
        m_reg[l][15] = 8'(l);
        m_rs[l] = 8'd0;
        m_rt[l] = 8'd0;
      end
    end else if (enable) begin
      for (int l = 0; l < T; l++) begin
        if (core_state == 3'b011 && thread_mask[l]) begin
          m_rs[l] = m_reg[l][rs_addr];
          m_rt[l] = m_reg[l][rt_addr];
        end
        if (core_state == 3'b110 && reg_we && thread_mask[l] && rd_addr < 13 && reg_mux != 2'b11)
          m_reg[l][rd_addr] = (reg_mux == 2'b00) ? alu_out[l] :
                              (reg_mux == 2'b01) ? lsu_out[l] : imm;
        m_reg[l][13] = block_id;
      end
    end
    #1;
    for (int l = 0; l < T; l++) begin
      check_eq($sformatf("model_rs%0d", l), rs[l], m_rs[l]);
      check_eq($sformatf("model_rt%0d", l), rt[l], m_rt[l]);
    end
  endtask

  task automatic do_req(input logic [3:0] a, input logic [3:0] b, input logic [T-1:0] mask);
    core_state = 3'b011; rs_addr = a; rt_addr = b; thread_mask = mask;
    tick();
    core_state = 3'b000;
  endtask

  task automatic do_upd(input logic [3:0] d, input logic [1:0] mux, input logic [7:0] k,
                        input logic [T-1:0] mask);
    core_state = 3'b110; rd_addr = d; reg_mux = mux; imm = k; reg_we = 1'b1; thread_mask = mask;
    tick();
    core_state = 3'b000; reg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; core_state = 3'b000; thread_mask = '1; block_id = 8'd0;
    rd_addr = '0; rs_addr = '0; rt_addr = '0; reg_we = 1'b0; reg_mux = 2'b00; imm = 8'd0;
    alu_out = '0; lsu_out = '0;
    #1;
    tick(); tick();
    for (int l = 0; l < T; l++) check_eq("reset_rs", rs[l], 8'd0);
    reset = 1'b0;

    // Identity registers after reset
    do_req(4'd15, 4'd14, 4'hF);
    for (int l = 0; l < T; l++) begin
      check_eq("r15_lane", rs[l], 8'(l));
      check_eq("r14_dim", rt[l], 8'd4);
    end

    // Immediate broadcast
    do_upd(4'd3, 2'b10, 8'h5A, 4'hF);
    do_req(4'd3, 4'd0, 4'hF);
    for (int l = 0; l < T; l++) check_eq("imm_bcast", rs[l], 8'h5A);

    // Masked ALU write
    alu_out = {8'd9, 8'd8, 8'd7, 8'd6};
    do_upd(4'd1, 2'b00, 8'h00, 4'b0101);
    do_req(4'd1, 4'd0, 4'hF);
    check_eq("alu_l0", rs[0], 8'd6);
    check_eq("alu_l1", rs[1], 8'd0);
    check_eq("alu_l2", rs[2], 8'd8);
    check_eq("alu_l3", rs[3], 8'd0);

    // Write to read-only R14 dropped
    lsu_out = {T{8'hFF}};
    do_upd(4'd14, 2'b01, 8'h00, 4'hF);
    do_req(4'd14, 4'd14, 4'hF);
    for (int l = 0; l < T; l++) check_eq("r14_ro", rs[l], 8'd4);

    // R13 refresh frozen while disabled, pre-refresh value on same-cycle read
    block_id = 8'd7; enable = 1'b0;
    tick(); tick(); tick();
    enable = 1'b1;
    do_req(4'd13, 4'd13, 4'hF);
    for (int l = 0; l < T; l++) check_eq("r13_old", rs[l], 8'd0);
    do_req(4'd13, 4'd13, 4'hF);
    for (int l = 0; l < T; l++) check_eq("r13_new", rs[l], 8'd7);

    // Reset wins during REQUEST
    do_upd(4'd2, 2'b10, 8'h33, 4'hF);
    reset = 1'b1;
    do_req(4'd2, 4'd2, 4'hF);
    for (int l = 0; l < T; l++) check_eq("rst_req", rs[l], 8'd0);
    reset = 1'b0;
    do_req(4'd2, 4'd2, 4'hF);
    for (int l = 0; l < T; l++) check_eq("r2_cleared", rs[l], 8'd0);

    // Randomized traffic; the model compares every cycle
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 79) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      core_state  = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? 3'b011 : 3'b110)
                                                : 3'($urandom);
      thread_mask = T'($urandom);
      block_id    = 8'($urandom);
      rd_addr     = 4'($urandom);
      rs_addr     = 4'($urandom);
      rt_addr     = 4'($urandom);
      reg_we      = ($urandom_range(0, 3) != 0);
      reg_mux     = 2'($urandom);
      imm         = 8'($urandom);
      for (int l = 0; l < T; l++) begin
        alu_out[l] = 8'($urandom);
        lsu_out[l] = 8'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
